// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_pkg
//  Description : Shared LCD constants, pixel types and UART receiver states
//                for the 240x135 RGB565 panel datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

  localparam int LCD_W                = 240;
  localparam int LCD_H                = 135;
  localparam int FRAME_PIXELS_DEFAULT = LCD_W * LCD_H;

  typedef logic [15:0] pixel_t;

  localparam pixel_t RGB_RED   = 16'hF800;
  localparam pixel_t RGB_GREEN = 16'h07E0;
  localparam pixel_t RGB_BLUE  = 16'h001F;

  // One pixel FIFO entry with its frame markers
  typedef struct packed {
    logic   first;
    logic   last;
    pixel_t data;
  } pix_entry_t;

  // UART receiver states; RX_WAIT parks after a framing error until the line is high
  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_WAIT  = 3'd4
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_pixel_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pixel_feeder_if
//  Description : Valid/ready RGB565 pixel stream with frame markers.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_pixel_feeder_if;
  import lcd_pkg::*;

  pixel_t pix_data;
  logic   pix_first;
  logic   pix_last;
  logic   pix_valid;
  logic   pix_ready;

  modport master (
    output pix_data, pix_first, pix_last, pix_valid,
    input  pix_ready
  );

  modport slave (
    input  pix_data, pix_first, pix_last, pix_valid,
    output pix_ready
  );

endinterface
`default_nettype wire

// File: rtl/uart_rx_8n1.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_8n1
//  Description : 8N1 UART receiver with 2-FF input synchroniser, mid-bit
//                sampling, false-start rejection and framing-error detect.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_8n1
  import lcd_pkg::*;
#(
  parameter int CLK_HZ = 27000000,
  parameter int BAUD   = 115200
) (
  input  wire logic       clk,
  input  wire logic       resetn,
  input  wire logic       ser_rx,
  output logic            rx_sync,
  output logic            byte_valid,
  output logic [7:0]      byte_data,
  output logic            frame_err
);

  localparam int c_div   = CLK_HZ / BAUD;
  localparam int c_half  = c_div / 2;
  localparam int c_cnt_w = (c_div > 2) ? $clog2(c_div) : 1;

  logic              r_sync1, r_sync2, r_prev;
  rx_state_t         r_state, w_state_nx;
  logic [c_cnt_w-1:0] r_cnt, w_cnt_nx;
  logic [2:0]        r_bit, w_bit_nx;
  logic [7:0]        r_shift, w_shift_nx;
  logic              r_byte_valid, w_byte_valid_nx;
  logic              r_frame_err, w_frame_err_nx;

  // Bring the asynchronous line into the clock domain; idle level is high
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= ser_rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Receiver state, baud counter, bit index, shift register and output pulses
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= RX_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      r_bit        <= w_bit_nx;
      r_shift      <= w_shift_nx;
      r_byte_valid <= w_byte_valid_nx;
      r_frame_err  <= w_frame_err_nx;
    end
  end

  // Next-state logic: half-bit start check, then one sample per full bit period
  always_comb begin
    w_state_nx      = r_state;
    w_cnt_nx        = r_cnt + 1'b1;
    w_bit_nx        = r_bit;
    w_shift_nx      = r_shift;
    w_byte_valid_nx = 1'b0;
    w_frame_err_nx  = 1'b0;
    case (r_state)
      RX_IDLE: begin
        w_cnt_nx = '0;
        if (r_prev && !r_sync2) w_state_nx = RX_START;
      end
      RX_START: begin
        if (r_cnt == c_cnt_w'(c_half - 1)) begin
          w_cnt_nx   = '0;
          w_bit_nx   = '0;
          w_state_nx = r_sync2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_cnt == c_cnt_w'(c_div - 1)) begin
          w_cnt_nx   = '0;
          w_shift_nx = {r_sync2, r_shift[7:1]};
          w_bit_nx   = r_bit + 1'b1;
          if (r_bit == 3'd7) w_state_nx = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_cnt == c_cnt_w'(c_div - 1)) begin
          w_cnt_nx = '0;
          if (r_sync2) begin
            w_byte_valid_nx = 1'b1;
            w_state_nx      = RX_IDLE;
          end else begin
            w_frame_err_nx  = 1'b1;
            w_state_nx      = RX_WAIT;
          end
        end
      end
      RX_WAIT: begin
        w_cnt_nx = '0;
        if (r_sync2) w_state_nx = RX_IDLE;
      end
      default: begin
        w_cnt_nx   = '0;
        w_state_nx = RX_IDLE;
      end
    endcase
  end

  assign rx_sync    = r_sync2;
  assign byte_valid = r_byte_valid;
  assign byte_data  = r_shift;
  assign frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: rtl/uart_pixel_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pixel_feeder
//  Description : UART frame receiver that packs byte pairs into RGB565
//                pixels, buffers them in a FIFO and streams them out with
//                frame first/last markers.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_pixel_feeder
  import lcd_pkg::*;
#(
  parameter int CLK_HZ       = 27000000,
  parameter int BAUD         = 115200,
  parameter int FIFO_DEPTH   = 64,
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEFAULT,
  parameter int GAP_BITS     = 20
) (
  input  wire logic          clk,
  input  wire logic          resetn,
  input  wire logic          ser_rx,
  uart_pixel_feeder_if.master pix,
  output logic               overflow,
  output logic               rx_err,
  input  wire logic          clear_err
);

  localparam int c_div     = CLK_HZ / BAUD;
  localparam int c_gap_cyc = GAP_BITS * c_div;
  localparam int c_idle_w  = $clog2(c_gap_cyc + 1);
  localparam int c_cnt_w   = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam int c_ptr_w   = $clog2(FIFO_DEPTH);

  logic        w_rx_sync, w_byte_valid, w_frame_err;
  logic [7:0]  w_byte_data;

  uart_rx_8n1 #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_rx (
    .clk        (clk),
    .resetn     (resetn),
    .ser_rx     (ser_rx),
    .rx_sync    (w_rx_sync),
    .byte_valid (w_byte_valid),
    .byte_data  (w_byte_data),
    .frame_err  (w_frame_err)
  );

  logic                r_phase;
  logic [7:0]          r_hi;
  logic [c_cnt_w-1:0]  r_pix_cnt;
  logic [c_idle_w-1:0] r_idle_cnt;
  logic                w_resync, w_push, w_pix_last;
  pix_entry_t          w_entry;

  logic [c_ptr_w:0]    r_wr, r_rd, w_rd_nx;
  pix_entry_t          r_mem [FIFO_DEPTH];
  pix_entry_t          r_out;
  logic                r_valid, w_valid_nx;
  logic                w_pop, w_full, w_wr_en, w_drop;
  logic                r_overflow, r_rx_err;

  assign w_pix_last = (r_pix_cnt == c_cnt_w'(FRAME_PIXELS - 1));
  assign w_resync   = (r_idle_cnt == c_idle_w'(c_gap_cyc)) && (r_phase || (r_pix_cnt != '0));
  assign w_push     = w_byte_valid && r_phase && !w_resync;

  // Build the FIFO entry from the stored high byte and the incoming low byte
  always_comb begin
    w_entry.first = (r_pix_cnt == '0);
    w_entry.last  = w_pix_last;
    w_entry.data  = {r_hi, w_byte_data};
  end

  // Count high line samples; a long enough gap realigns the frame
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_idle_cnt <= '0;
    end else if (!w_rx_sync) begin
      r_idle_cnt <= '0;
    end else if (r_idle_cnt != c_idle_w'(c_gap_cyc)) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  // Byte-pair packer and frame pixel counter; dropped pixels still advance the count
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_phase   <= 1'b0;
      r_hi      <= '0;
      r_pix_cnt <= '0;
    end else if (w_resync) begin
      r_phase   <= 1'b0;
      r_pix_cnt <= '0;
    end else if (w_byte_valid) begin
      if (!r_phase) begin
        r_hi    <= w_byte_data;
        r_phase <= 1'b1;
      end else begin
        r_phase   <= 1'b0;
        r_pix_cnt <= w_pix_last ? '0 : r_pix_cnt + 1'b1;
      end
    end
  end

  // The head entry stays in the FIFO until it is transferred, so the output
  // register never adds capacity beyond FIFO_DEPTH
  assign w_pop      = r_valid && pix.pix_ready;
  assign w_full     = (r_wr[c_ptr_w] != r_rd[c_ptr_w]) &&
                      (r_wr[c_ptr_w-1:0] == r_rd[c_ptr_w-1:0]);
  assign w_wr_en    = w_push && (!w_full || w_pop);
  assign w_drop     = w_push && w_full && !w_pop;
  assign w_rd_nx    = r_rd + (c_ptr_w + 1)'(w_pop);
  assign w_valid_nx = (r_wr != w_rd_nx);

  // FIFO storage, written only when the entry is accepted
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr[c_ptr_w-1:0]] <= w_entry;
  end

  // Pointers and registered first-word-fall-through output stage
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_valid <= 1'b0;
      r_out   <= '0;
    end else begin
      if (w_wr_en) r_wr <= r_wr + 1'b1;
      r_rd    <= w_rd_nx;
      r_valid <= w_valid_nx;
      if (w_valid_nx) r_out <= r_mem[w_rd_nx[c_ptr_w-1:0]];
    end
  end

  // Sticky error flags; a clear wins over a same-cycle set
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_overflow <= 1'b0;
      r_rx_err   <= 1'b0;
    end else if (clear_err) begin
      r_overflow <= 1'b0;
      r_rx_err   <= 1'b0;
    end else begin
      if (w_drop)      r_overflow <= 1'b1;
      if (w_frame_err) r_rx_err   <= 1'b1;
    end
  end

  assign pix.pix_data  = r_out.data;
  assign pix.pix_first = r_out.first;
  assign pix.pix_last  = r_out.last;
  assign pix.pix_valid = r_valid;
  assign overflow      = r_overflow;
  assign rx_err        = r_rx_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_pixel_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_pixel_feeder
//  Description : Self-checking bench for uart_pixel_feeder with a pixel
//                scoreboard fed by the UART stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_pixel_feeder;

  localparam int CLK_HZ       = 160;
  localparam int BAUD         = 10;
  localparam int DIV          = CLK_HZ / BAUD;
  localparam int FIFO_DEPTH   = 4;
  localparam int FRAME_PIXELS = 4;
  localparam int GAP_BITS     = 20;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic ser_rx = 1'b1;
  logic clear_err = 1'b0;
  logic overflow, rx_err;

  uart_pixel_feeder_if pix ();

  uart_pixel_feeder #(
    .CLK_HZ       (CLK_HZ),
    .BAUD         (BAUD),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .FRAME_PIXELS (FRAME_PIXELS),
    .GAP_BITS     (GAP_BITS)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ser_rx    (ser_rx),
    .pix       (pix),
    .overflow  (overflow),
    .rx_err    (rx_err),
    .clear_err (clear_err)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // {first, last, data}
  logic [17:0] exp_q[$];
  logic [17:0] obs_q[$];

  // Record every completed transfer, sampled mid-cycle
  always @(negedge clk) begin
    if (resetn === 1'b1 && pix.pix_valid === 1'b1 && pix.pix_ready === 1'b1)
      obs_q.push_back({pix.pix_first, pix.pix_last, pix.pix_data});
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    ser_rx = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      tick(DIV);
    end
    ser_rx = stop_ok;
    tick(DIV);
    ser_rx = 1'b1;
    tick(DIV);
  endtask

  task automatic send_pixel(input logic [15:0] p, input logic first, input logic last);
    exp_q.push_back({first, last, p});
    send_byte(p[15:8], 1'b1);
    send_byte(p[7:0], 1'b1);
  endtask

  task automatic wait_obs(input int n);
    int cyc;
    cyc = 0;
    while (obs_q.size() < n && cyc < 20 * DIV) begin
      tick(1);
      cyc++;
    end
    tick(4);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    ser_rx = 1'b1;
    clear_err = 1'b0;
    tick(3);
    resetn = 1'b1;
    tick(3);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    pix.pix_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ser_rx = ~ser_rx;
      tick(3);
    end
    ser_rx = 1'b1;
    tick(1);
    tests_run++;
    if ({pix.pix_valid, pix.pix_first, pix.pix_last, overflow, rx_err} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_flags got %b required 00000",
               {pix.pix_valid, pix.pix_first, pix.pix_last, overflow, rx_err});
    end
    tests_run++;
    if (pix.pix_data !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_data got %h required 0000", pix.pix_data);
    end
    resetn = 1'b1;
    tick(20 * DIV);
    tests_run++;
    if (pix.pix_valid !== 1'b0 || obs_q.size() != 0) begin
      tests_failed++;
      $display("FAIL reset_quiet valid %b transfers %0d required 0 0", pix.pix_valid, obs_q.size());
    end
  endtask

  task automatic test_single_pixel();
    logic [17:0] got, want;
    do_reset();
    pix.pix_ready = 1'b1;
    send_pixel(16'hF800, 1'b1, 1'b0);
    wait_obs(1);
    tick(4 * DIV);
    tests_run++;
    if (obs_q.size() != 1) begin
      tests_failed++;
      $display("FAIL single_count got %0d required 1", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      got = obs_q.pop_front();
      want = exp_q.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL single_pixel got %h required %h", got, want);
      end
    end
  endtask

  task automatic test_full_frame();
    logic [17:0] got, want;
    do_reset();
    pix.pix_ready = 1'b1;
    for (int i = 0; i < 5; i++)
      send_pixel(16'h1111 * (i + 1), (i % FRAME_PIXELS) == 0, (i % FRAME_PIXELS) == FRAME_PIXELS - 1);
    wait_obs(5);
    tests_run++;
    if (obs_q.size() != 5) begin
      tests_failed++;
      $display("FAIL frame_count got %0d required 5", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      got = obs_q.pop_front();
      want = exp_q.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL frame_pixel got %h required %h", got, want);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [17:0] got, want;
    do_reset();
    pix.pix_ready = 1'b0;
    for (int i = 0; i < FIFO_DEPTH + 2; i++) begin
      if (i < FIFO_DEPTH)
        send_pixel({8'hA0 + 8'(i), 8'h50 + 8'(i)}, (i % FRAME_PIXELS) == 0,
                   (i % FRAME_PIXELS) == FRAME_PIXELS - 1);
      else begin
        send_byte(8'hA0 + 8'(i), 1'b1);
        send_byte(8'h50 + 8'(i), 1'b1);
      end
    end
    tick(4);
    tests_run++;
    if (overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_overflow got %b required 1", overflow);
    end
    tests_run++;
    if (pix.pix_valid !== 1'b1 || pix.pix_data !== 16'hA050) begin
      tests_failed++;
      $display("FAIL bp_hold valid %b data %h required 1 a050", pix.pix_valid, pix.pix_data);
    end
    pix.pix_ready = 1'b1;
    wait_obs(FIFO_DEPTH);
    tick(20);
    tests_run++;
    if (obs_q.size() != FIFO_DEPTH) begin
      tests_failed++;
      $display("FAIL bp_count got %0d required %0d", obs_q.size(), FIFO_DEPTH);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      got = obs_q.pop_front();
      want = exp_q.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL bp_order got %h required %h", got, want);
      end
    end
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    tick(1);
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_clear got %b required 0", overflow);
    end
  endtask

  task automatic test_framing_error();
    logic [17:0] got, want;
    do_reset();
    pix.pix_ready = 1'b1;
    ser_rx = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      ser_rx = (i % 2) == 0;
      tick(DIV);
    end
    ser_rx = 1'b0;
    tick(2 * DIV);
    ser_rx = 1'b1;
    tick(2 * DIV);
    tests_run++;
    if (rx_err !== 1'b1 || obs_q.size() != 0) begin
      tests_failed++;
      $display("FAIL ferr_flag rx_err %b transfers %0d required 1 0", rx_err, obs_q.size());
    end
    send_pixel(16'h1234, 1'b1, 1'b0);
    wait_obs(1);
    tests_run++;
    if (obs_q.size() != 1) begin
      tests_failed++;
      $display("FAIL ferr_count got %0d required 1", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      got = obs_q.pop_front();
      want = exp_q.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL ferr_recover got %h required %h", got, want);
      end
    end
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    tick(1);
    tests_run++;
    if (rx_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL ferr_clear got %b required 0", rx_err);
    end
  endtask

  task automatic test_resync();
    logic [17:0] got, want;
    do_reset();
    pix.pix_ready = 1'b1;
    send_byte(8'hAB, 1'b1);
    tick((GAP_BITS + 1) * DIV);
    send_pixel(16'h07E0, 1'b1, 1'b0);
    wait_obs(1);
    // false start: low glitch well under half a bit
    ser_rx = 1'b0;
    tick(DIV / 4);
    ser_rx = 1'b1;
    tick(12 * DIV);
    tests_run++;
    if (obs_q.size() != 1 || rx_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch_effect transfers %0d rx_err %b required 1 0", obs_q.size(), rx_err);
    end
    send_pixel(16'h001F, 1'b0, 1'b0);
    wait_obs(2);
    tests_run++;
    if (obs_q.size() != 2) begin
      tests_failed++;
      $display("FAIL resync_count got %0d required 2", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      got = obs_q.pop_front();
      want = exp_q.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL resync_pixel got %h required %h", got, want);
      end
    end
  endtask

  initial begin
    pix.pix_ready = 1'b0;
    test_reset();
    test_single_pixel();
    test_full_frame();
    test_backpressure();
    test_framing_error();
    test_resync();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
